umstr_ethii_rx_parser: RTL and testbench



---
 rtl/umstr_ethII_pkg.sv | 19 +
 rtl/umstr_ethII_realign.sv | 56 +++++
 rtl/umstr_ethii_rx_parser.sv | 200 ++++++++++++++++++++
 tb/tb_umstr_ethii_rx_parser.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/umstr_ethII_pkg.sv
// rtl/umstr_ethII_pkg.sv - Ethernet II RX deframer constants and FSM state type
package umstr_ethII_pkg;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [47:0] ETH_MAC_BCAST = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ST_H0,
        ST_H1,
        ST_H2,
        ST_H3,
        ST_HDR,
        ST_PAY,
        ST_FLUSH,
        ST_DROP
    } rx_state_e;

endpackage

// File: rtl/umstr_ethII_realign.sv
// rtl/umstr_ethII_realign.sv - shifts the payload up 16 bits so byte 14 of the frame lands on a 32-bit boundary
module umstr_ethII_realign
    import umstr_ethII_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_tdata,
    input  logic [3:0]  in_tkeep,
    input  logic        in_tlast,
    input  logic        load_hold,
    input  logic        pay_accept,
    input  logic        flush_req,
    input  logic        out_rdy,
    output logic [31:0] out_tdata,
    output logic [3:0]  out_tkeep,
    output logic        out_tvld,
    output logic        out_tlast,
    output logic        out_free
);

    logic [15:0] hold;
    logic [1:0]  hold_keep;

    assign out_free = !out_tvld || out_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_keep <= '0;
            out_tdata <= '0;
            out_tkeep <= '0;
            out_tvld  <= 1'b0;
            out_tlast <= 1'b0;
        end else begin
            if (load_hold || pay_accept) begin
                hold      <= in_tdata[15:0];
                hold_keep <= in_tkeep[1:0];
            end
            // pay_accept is only raised while the output slot is free
            if (pay_accept) begin
                out_tdata <= {hold, in_tdata[31:16]};
                out_tkeep <= {hold_keep, in_tkeep[3:2]};
                out_tlast <= in_tlast && !in_tkeep[1];
                out_tvld  <= 1'b1;
            end else if (flush_req && out_free) begin
                out_tdata <= {hold, 16'h0000};
                out_tkeep <= {hold_keep, 2'b00};
                out_tlast <= 1'b1;
                out_tvld  <= 1'b1;
            end else if (out_rdy) begin
                out_tvld  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/umstr_ethii_rx_parser.sv
// rtl/umstr_ethii_rx_parser.sv - Ethernet II RX deframer steering payload to ARP or IPv4
// Optional destination filter: UMSTR_ETHII_RX_MAC_FILTER_EN
module umstr_ethii_rx_parser
    import umstr_ethII_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] eth_rx_tdata_i,
    input  logic [3:0]  eth_rx_tkeep_i,
    input  logic        eth_rx_tvld_i,
    input  logic        eth_rx_tlast_i,
    output logic        eth_rx_trdy_o,
    output logic [47:0] arp_mac_dest_o,
    output logic [47:0] arp_mac_src_o,
    output logic [15:0] arp_mac_type_o,
    output logic        arp_mac_vld_o,
    input  logic        arp_mac_rdy_i,
    output logic [31:0] arp_tdata_o,
    output logic [3:0]  arp_tkeep_o,
    output logic        arp_tvld_o,
    output logic        arp_tlast_o,
    input  logic        arp_trdy_i,
    output logic [47:0] ipv4_mac_dest_o,
    output logic [47:0] ipv4_mac_src_o,
    output logic [15:0] ipv4_mac_type_o,
    output logic        ipv4_mac_vld_o,
    input  logic        ipv4_mac_rdy_i,
    output logic [31:0] ipv4_tdata_o,
    output logic [3:0]  ipv4_tkeep_o,
    output logic        ipv4_tvld_o,
    output logic        ipv4_tlast_o,
    input  logic        ipv4_trdy_i,
`ifdef UMSTR_ETHII_RX_MAC_FILTER_EN
    input  logic [47:0] local_mac_i,
`endif
    output logic [15:0] drop_cnt_o
);

    rx_state_e   state, nxt;
    logic        live;
    logic [47:0] mac_dest, mac_src;
    logic [15:0] mac_type;
    logic        sel_arp, out_is_arp, b3_last;
    logic        cnt_inc, in_acc, hdr_rdy, out_rdy, dest_reject;
    logic        pay_accept, load_hold, flush_req;
    logic [31:0] rl_tdata;
    logic [3:0]  rl_tkeep;
    logic        rl_tvld, rl_tlast, rl_free;
    logic [15:0] b3_type;

    assign in_acc     = eth_rx_tvld_i && eth_rx_trdy_o;
    assign b3_type    = eth_rx_tdata_i[31:16];
    assign hdr_rdy    = sel_arp ? arp_mac_rdy_i : ipv4_mac_rdy_i;
    // The output register may still hold the previous frame's last beat, so route by its owner
    assign out_rdy    = out_is_arp ? arp_trdy_i : ipv4_trdy_i;
    assign pay_accept = (state == ST_PAY) && in_acc;
    assign load_hold  = (state == ST_H3) && in_acc;
    assign flush_req  = (state == ST_FLUSH);

`ifdef UMSTR_ETHII_RX_MAC_FILTER_EN
    assign dest_reject = ({mac_dest[47:16], eth_rx_tdata_i[31:16]} != local_mac_i) &&
                         ({mac_dest[47:16], eth_rx_tdata_i[31:16]} != ETH_MAC_BCAST);
`else
    assign dest_reject = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_H0;
            live  <= 1'b0;
        end else begin
            state <= nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_inc = 1'b0;
        case (state)
            ST_H0: if (in_acc) begin
                nxt     = eth_rx_tlast_i ? ST_H0 : ST_H1;
                cnt_inc = eth_rx_tlast_i;
            end
            ST_H1: if (in_acc) begin
                if (eth_rx_tlast_i) begin
                    nxt     = ST_H0;
                    cnt_inc = 1'b1;
                end else if (dest_reject) begin
                    nxt     = ST_DROP;
                    cnt_inc = 1'b1;
                end else begin
                    nxt     = ST_H2;
                end
            end
            ST_H2: if (in_acc) begin
                nxt     = eth_rx_tlast_i ? ST_H0 : ST_H3;
                cnt_inc = eth_rx_tlast_i;
            end
            ST_H3: if (in_acc) begin
                if (eth_rx_tlast_i && !eth_rx_tkeep_i[1]) begin
                    nxt     = ST_H0;
                    cnt_inc = 1'b1;
                end else if (b3_type == ETH_TYPE_ARP || b3_type == ETH_TYPE_IPV4) begin
                    nxt     = ST_HDR;
                end else begin
                    nxt     = eth_rx_tlast_i ? ST_H0 : ST_DROP;
                    cnt_inc = 1'b1;
                end
            end
            ST_HDR:   if (hdr_rdy) nxt = b3_last ? ST_FLUSH : ST_PAY;
            ST_PAY:   if (in_acc && eth_rx_tlast_i) nxt = eth_rx_tkeep_i[1] ? ST_FLUSH : ST_H0;
            ST_FLUSH: if (rl_free) nxt = ST_H0;
            ST_DROP:  if (in_acc && eth_rx_tlast_i) nxt = ST_H0;
            default:  nxt = ST_H0;
        endcase
    end

    always_comb begin
        eth_rx_trdy_o  = 1'b0;
        arp_mac_vld_o  = 1'b0;
        ipv4_mac_vld_o = 1'b0;
        case (state)
            ST_H0, ST_H1, ST_H2, ST_H3, ST_DROP: eth_rx_trdy_o = live;
            ST_PAY:  eth_rx_trdy_o = rl_free;
            ST_HDR: begin
                arp_mac_vld_o  = sel_arp;
                ipv4_mac_vld_o = !sel_arp;
            end
            default: eth_rx_trdy_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_dest   <= '0;
            mac_src    <= '0;
            mac_type   <= '0;
            sel_arp    <= 1'b0;
            b3_last    <= 1'b0;
            out_is_arp <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            if (in_acc) begin
                case (state)
                    ST_H0: mac_dest[47:16] <= eth_rx_tdata_i;
                    ST_H1: begin
                        mac_dest[15:0]  <= eth_rx_tdata_i[31:16];
                        mac_src[47:32]  <= eth_rx_tdata_i[15:0];
                    end
                    ST_H2: mac_src[31:0] <= eth_rx_tdata_i;
                    ST_H3: begin
                        mac_type <= b3_type;
                        sel_arp  <= (b3_type == ETH_TYPE_ARP);
                        b3_last  <= eth_rx_tlast_i;
                    end
                    default: ;
                endcase
            end
            if (pay_accept || (flush_req && rl_free))
                out_is_arp <= sel_arp;
            if (cnt_inc)
                drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end

    umstr_ethII_realign u_realign (
        .clk        (clk),
        .reset      (reset),
        .in_tdata   (eth_rx_tdata_i),
        .in_tkeep   (eth_rx_tkeep_i),
        .in_tlast   (eth_rx_tlast_i),
        .load_hold  (load_hold),
        .pay_accept (pay_accept),
        .flush_req  (flush_req),
        .out_rdy    (out_rdy),
        .out_tdata  (rl_tdata),
        .out_tkeep  (rl_tkeep),
        .out_tvld   (rl_tvld),
        .out_tlast  (rl_tlast),
        .out_free   (rl_free)
    );

    assign arp_mac_dest_o  = mac_dest;
    assign arp_mac_src_o   = mac_src;
    assign arp_mac_type_o  = mac_type;
    assign ipv4_mac_dest_o = mac_dest;
    assign ipv4_mac_src_o  = mac_src;
    assign ipv4_mac_type_o = mac_type;

    assign arp_tdata_o  = rl_tdata;
    assign arp_tkeep_o  = rl_tkeep;
    assign arp_tlast_o  = rl_tlast;
    assign arp_tvld_o   = rl_tvld && out_is_arp;
    assign ipv4_tdata_o = rl_tdata;
    assign ipv4_tkeep_o = rl_tkeep;
    assign ipv4_tlast_o = rl_tlast;
    assign ipv4_tvld_o  = rl_tvld && !out_is_arp;

endmodule

// File: tb/tb_umstr_ethii_rx_parser.sv
// tb/tb_umstr_ethii_rx_parser.sv - scoreboard bench for the Ethernet II RX deframer
module tb_umstr_ethii_rx_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rx_tdata;
    logic [3:0]  rx_tkeep;
    logic        rx_tvld, rx_tlast, rx_trdy;
    logic [47:0] arp_dest, arp_src, ip_dest, ip_src;
    logic [15:0] arp_type, ip_type, drop_cnt;
    logic        arp_mvld, arp_mrdy, ip_mvld, ip_mrdy;
    logic [31:0] arp_tdata, ip_tdata;
    logic [3:0]  arp_tkeep, ip_tkeep;
    logic        arp_tvld, arp_tlast, arp_trdy, ip_tvld, ip_tlast, ip_trdy;
`ifdef UMSTR_ETHII_RX_MAC_FILTER_EN
    logic [47:0] local_mac = 48'h0200_0000_0001;
`endif

    always #5 clk = ~clk;

    umstr_ethii_rx_parser dut (
        .clk             (clk),
        .reset           (reset),
        .eth_rx_tdata_i  (rx_tdata),
        .eth_rx_tkeep_i  (rx_tkeep),
        .eth_rx_tvld_i   (rx_tvld),
        .eth_rx_tlast_i  (rx_tlast),
        .eth_rx_trdy_o   (rx_trdy),
        .arp_mac_dest_o  (arp_dest),
        .arp_mac_src_o   (arp_src),
        .arp_mac_type_o  (arp_type),
        .arp_mac_vld_o   (arp_mvld),
        .arp_mac_rdy_i   (arp_mrdy),
        .arp_tdata_o     (arp_tdata),
        .arp_tkeep_o     (arp_tkeep),
        .arp_tvld_o      (arp_tvld),
        .arp_tlast_o     (arp_tlast),
        .arp_trdy_i      (arp_trdy),
        .ipv4_mac_dest_o (ip_dest),
        .ipv4_mac_src_o  (ip_src),
        .ipv4_mac_type_o (ip_type),
        .ipv4_mac_vld_o  (ip_mvld),
        .ipv4_mac_rdy_i  (ip_mrdy),
        .ipv4_tdata_o    (ip_tdata),
        .ipv4_tkeep_o    (ip_tkeep),
        .ipv4_tvld_o     (ip_tvld),
        .ipv4_tlast_o    (ip_tlast),
        .ipv4_trdy_i     (ip_trdy),
`ifdef UMSTR_ETHII_RX_MAC_FILTER_EN
        .local_mac_i     (local_mac),
`endif
        .drop_cnt_o      (drop_cnt)
    );

    typedef struct { logic is_arp; logic [47:0] dest; logic [47:0] src; logic [15:0] typ; } hdr_t;
    typedef struct { logic is_arp; logic [31:0] data; logic [3:0] keep; logic last; } beat_t;

    hdr_t       hdr_q[$];
    beat_t      pay_q[$];
    int         total = 0;
    int         bad = 0;
    int         stall_cnt = 0;
    int         exp_drop = 0;
    logic       bp_en = 1'b0;
    logic [7:0] fb [0:255];

    localparam logic [47:0] MAC_LOCAL = 48'h0200_0000_0001;
    localparam logic [47:0] MAC_OTHER = 48'h0200_0000_0002;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MAC_SRC   = 48'h0A0B_0C0D_0E0F;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic build(input logic [47:0] dest, input logic [15:0] typ, input int len, input logic [7:0] seed);
        for (int i = 0; i < 6; i++) begin
            fb[i]     = dest[47-8*i -: 8];
            fb[6 + i] = MAC_SRC[47-8*i -: 8];
        end
        fb[12] = typ[15:8];
        fb[13] = typ[7:0];
        for (int i = 14; i < len; i++) fb[i] = seed + 8'(i);
    endtask

    task automatic expect_frame(input logic is_arp, input int len);
        hdr_t  h;
        beat_t b;
        h.is_arp = is_arp;
        h.dest   = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
        h.src    = {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
        h.typ    = {fb[12], fb[13]};
        hdr_q.push_back(h);
        for (int p = 14; p < len; p += 4) begin
            b.is_arp = is_arp;
            b.data   = '0;
            b.keep   = '0;
            for (int k = 0; k < 4; k++) begin
                if (p + k < len) begin
                    b.data[31-8*k -: 8] = fb[p+k];
                    b.keep[3-k]         = 1'b1;
                end
            end
            b.last = (p + 4 >= len);
            pay_q.push_back(b);
        end
    endtask

    task automatic send(input int len);
        int nb;
        nb = (len + 3) / 4;
        stall_cnt = 0;
        for (int b = 0; b < nb; b++) begin
            int to;
            logic [31:0] d;
            logic [3:0]  kp;
            d  = '0;
            kp = '0;
            for (int k = 0; k < 4; k++) begin
                if (4*b + k < len) begin
                    d[31-8*k -: 8] = fb[4*b + k];
                    kp[3-k]        = 1'b1;
                end
            end
            rx_tdata = d;
            rx_tkeep = kp;
            rx_tlast = (b == nb - 1);
            rx_tvld  = 1'b1;
            to = 0;
            forever begin
                @(negedge clk);
                if (rx_trdy) break;
                stall_cnt++;
                to++;
                if (to > 300) begin
                    chk("rx_accept_timeout", 1, 0);
                    rx_tvld = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        rx_tvld  = 1'b0;
        rx_tlast = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((hdr_q.size() != 0 || pay_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("drain_hdr", 64'(hdr_q.size()), 0);
        chk("drain_pay", 64'(pay_q.size()), 0);
        chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        @(posedge clk);
        #1;
    endtask

    task automatic pop_hdr(input logic is_arp, input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
        hdr_t e;
        if (hdr_q.size() == 0) begin
            chk("hdr_unexpected", 1, 0);
            return;
        end
        e = hdr_q.pop_front();
        chk("hdr_port_type", {is_arp, t}, {e.is_arp, e.typ});
        chk("hdr_dest", d, e.dest);
        chk("hdr_src", s, e.src);
    endtask

    task automatic pop_pay(input logic is_arp, input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t e;
        if (pay_q.size() == 0) begin
            chk("pay_unexpected", 1, 0);
            return;
        end
        e = pay_q.pop_front();
        chk("pay_beat", {is_arp, l, k, d}, {e.is_arp, e.last, e.keep, e.data});
    endtask

    // Consumer readiness: always ready unless backpressure is enabled
    initial begin
        arp_mrdy = 1'b1; ip_mrdy = 1'b1; arp_trdy = 1'b1; ip_trdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                arp_mrdy = 1'($urandom_range(0, 1));
                ip_mrdy  = 1'($urandom_range(0, 1));
                arp_trdy = 1'($urandom_range(0, 1));
                ip_trdy  = 1'($urandom_range(0, 1));
            end else begin
                arp_mrdy = 1'b1; ip_mrdy = 1'b1; arp_trdy = 1'b1; ip_trdy = 1'b1;
            end
        end
    end

    // Monitor: handshakes complete at the next rising edge, so sample on the falling edge
    initial begin
        logic        pay_pend, hdr_pend;
        logic [36:0] pay_val;
        logic [47:0] hdr_val;
        pay_pend = 1'b0;
        hdr_pend = 1'b0;
        pay_val  = '0;
        hdr_val  = '0;
        @(negedge reset);
        forever begin
            @(negedge clk);
            if (arp_mvld && ip_mvld) chk("hdr_both_vld", 1, 0);
            if (arp_tvld && ip_tvld) chk("pay_both_vld", 1, 0);
            if (pay_pend) chk("arp_pay_stable", {arp_tvld, arp_tlast, arp_tkeep, arp_tdata}, {1'b1, pay_val});
            if (hdr_pend) chk("arp_hdr_stable", {arp_mvld, arp_dest}, {1'b1, hdr_val});
            pay_pend = arp_tvld && !arp_trdy;
            pay_val  = {arp_tlast, arp_tkeep, arp_tdata};
            hdr_pend = arp_mvld && !arp_mrdy;
            hdr_val  = arp_dest;
            if (arp_mvld && arp_mrdy) pop_hdr(1'b1, arp_dest, arp_src, arp_type);
            if (ip_mvld && ip_mrdy)   pop_hdr(1'b0, ip_dest, ip_src, ip_type);
            if (arp_tvld && arp_trdy) pop_pay(1'b1, arp_tdata, arp_tkeep, arp_tlast);
            if (ip_tvld && ip_trdy)   pop_pay(1'b0, ip_tdata, ip_tkeep, ip_tlast);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx_tvld = 1'b0; rx_tlast = 1'b0; rx_tdata = '0; rx_tkeep = '0;
        repeat (3) @(negedge clk);
        chk("reset_trdy", rx_trdy, 0);
        chk("reset_vld", {arp_mvld, ip_mvld, arp_tvld, ip_tvld, arp_tlast, ip_tlast}, 0);
        chk("reset_fields", {arp_type, arp_tkeep, arp_tdata}, 0);
        chk("reset_mac", arp_dest ^ arp_src, 0);
        chk("reset_drop", drop_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        build(MAC_LOCAL, 16'h0806, 42, 8'h10);
        expect_frame(1'b1, 42);
        send(42);
        drain();

        build(MAC_LOCAL, 16'h0800, 35, 8'h40);
        expect_frame(1'b0, 35);
        send(35);
        drain();

        build(MAC_LOCAL, 16'h86DD, 80, 8'h70);
        send(80);
        chk("drop_trdy_stalls", 64'(stall_cnt), 0);
        exp_drop = 1;
        drain();

        build(MAC_LOCAL, 16'h0806, 12, 8'h00);
        send(12);
        build(MAC_LOCAL, 16'h0806, 42, 8'h90);
        expect_frame(1'b1, 42);
        send(42);
        exp_drop = 2;
        drain();

        bp_en = 1'b1;
        build(MAC_LOCAL, 16'h0806, 60, 8'hA0);
        expect_frame(1'b1, 60);
        send(60);
        build(MAC_LOCAL, 16'h0800, 64, 8'hC0);
        expect_frame(1'b0, 64);
        send(64);
        build(MAC_LOCAL, 16'h0806, 43, 8'h33);
        expect_frame(1'b1, 43);
        send(43);
        drain();
        bp_en = 1'b0;

        build(MAC_LOCAL, 16'h0800, 15, 8'h55);
        expect_frame(1'b0, 15);
        send(15);
        build(MAC_LOCAL, 16'h0806, 16, 8'h66);
        expect_frame(1'b1, 16);
        send(16);
        drain();

        build(MAC_LOCAL, 16'h0800, 14, 8'h00);
        send(14);
        build(MAC_LOCAL, 16'h1234, 16, 8'h00);
        send(16);
        exp_drop = 4;
        drain();

`ifdef UMSTR_ETHII_RX_MAC_FILTER_EN
        build(MAC_OTHER, 16'h0806, 42, 8'h21);
        send(42);
        build(MAC_BCAST, 16'h0806, 42, 8'h22);
        expect_frame(1'b1, 42);
        send(42);
        build(MAC_LOCAL, 16'h0800, 40, 8'h23);
        expect_frame(1'b0, 40);
        send(40);
        exp_drop = 5;
        drain();
`else
        build(MAC_OTHER, 16'h0806, 42, 8'h21);
        expect_frame(1'b1, 42);
        send(42);
        build(MAC_BCAST, 16'h0800, 40, 8'h22);
        expect_frame(1'b0, 40);
        send(40);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
